// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int PC_STEP          = 4;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int FCNT_W           = 4;
  localparam int CNT_W            = 32;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/branch bundle between the PC sequencer (master) and its surroundings (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W = 64
) ();
  import pc_seq_pkg::*;

  logic              stall;
  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_offset;
  logic              imem_ready;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              flush;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    input  stall, br_valid, br_taken, br_pc, br_offset, imem_ready,
    output imem_req, imem_addr, flush, taken_cnt
  );

  modport slave (
    output stall, br_valid, br_taken, br_pc, br_offset, imem_ready,
    input  imem_req, imem_addr, flush, taken_cnt
  );

endinterface

// File: rtl/pc_target_calc.sv
// Branch target adder: word offset scaled to bytes, added to the branch PC, word-aligned.
module pc_target_calc #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] sum;

  // Offset is already sign-extended, so a plain wrapping add handles backward branches.
  assign sum      = br_pc_i + (br_offset_i << 2);
  assign target_o = {sum[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register, request handshake, branch redirect with flush bubbles, taken-branch counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master seq_bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  logic [ADDR_W-1:0] target;
  logic              req;
  logic              accept;
  logic              redirect;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .br_pc_i     (seq_bus.br_pc),
    .br_offset_i (seq_bus.br_offset),
    .target_o    (target)
  );

  // Reset is gated in so no request leaks out while the sequencer is held in reset.
  assign req      = (state_q == FETCH) && !seq_bus.stall && !rst;
  assign accept   = req && seq_bus.imem_ready;
  assign redirect = seq_bus.br_valid && seq_bus.br_taken && (state_q == FETCH);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    pc_d        = pc_q;
    fcnt_d      = fcnt_q;
    flush_d     = 1'b0;
    taken_cnt_d = taken_cnt_q;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES);
          state_d = FLUSH;
          if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
        end else if (accept) begin
          pc_d = pc_q + ADDR_W'(PC_STEP);
        end
      end
      FLUSH: begin
        // Branch inputs here come from wrong-path instructions and are ignored.
        fcnt_d = fcnt_q - 1'b1;
        if (fcnt_q == FCNT_W'(1)) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      fcnt_q      <= '0;
      flush_q     <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fcnt_q      <= fcnt_d;
      flush_q     <= flush_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign seq_bus.imem_req  = req;
  assign seq_bus.imem_addr = pc_q;
  assign seq_bus.flush     = flush_q;
  assign seq_bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences, random vs. model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int          AW   = 64;
  localparam logic [63:0] RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(AW)) bus0 ();
  pc_sequencer_if #(.ADDR_W(AW)) bus1 ();

  pc_sequencer #(.ADDR_W(AW)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .seq_bus (bus0.master)
  );

  pc_sequencer #(.ADDR_W(AW), .RESET_PC(RPC1), .FLUSH_CYCLES(3)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .seq_bus (bus1.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic s, input logic v, input logic t,
                        input logic [63:0] bpc, input logic [63:0] boff, input logic rdy);
    bus0.stall = s; bus0.br_valid = v; bus0.br_taken = t;
    bus0.br_pc = bpc; bus0.br_offset = boff; bus0.imem_ready = rdy;
  endtask

  task automatic drive1(input logic s, input logic v, input logic t,
                        input logic [63:0] bpc, input logic [63:0] boff, input logic rdy);
    bus1.stall = s; bus1.br_valid = v; bus1.br_taken = t;
    bus1.br_pc = bpc; bus1.br_offset = boff; bus1.imem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out0(input string tag, input logic [63:0] a, input logic r,
                            input logic f, input logic [31:0] c);
    check({tag, " addr"},  bus0.imem_addr, a);
    check({tag, " req"},   64'(bus0.imem_req), 64'(r));
    check({tag, " flush"}, 64'(bus0.flush), 64'(f));
    check({tag, " cnt"},   64'(bus0.taken_cnt), 64'(c));
  endtask

  typedef struct {
    logic        stall, bv, bt;
    logic [63:0] bpc, boff;
    logic        rdy;
    logic [63:0] e_addr;
    logic        e_req, e_flush;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic s, logic v, logic t, logic [63:0] bpc, logic [63:0] boff,
                              logic rdy, logic [63:0] ea, logic er, logic ef, logic [31:0] ec);
    vec_t x;
    x.stall = s; x.bv = v; x.bt = t; x.bpc = bpc; x.boff = boff; x.rdy = rdy;
    x.e_addr = ea; x.e_req = er; x.e_flush = ef; x.e_cnt = ec;
    return x;
  endfunction

  vec_t vecs[18];

  // Reference model state: fetch PC, bubbles still to serve, flush pulse, taken count.
  logic [63:0] m_pc;
  int          m_bub;
  logic        m_flush;
  logic [31:0] m_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Sequential fetch, ready-low hold, redirect with concurrent accept, ignored branches,
    // stall-overridden redirect, unaligned branch PC. Expected values are post-edge.
    vecs[0]  = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'h4,    1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'h8,    1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'hC,    1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'h10,   1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 64'h0,    64'h0,   0, 64'h10,   1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 64'h0,    64'h0,   0, 64'h10,   1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 64'h0,    64'h0,   0, 64'h10,   1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'h14,   1, 0, 0);
    vecs[8]  = mk(0, 1, 1, 64'h100,  '1 << 2, 1, 64'hF0,   0, 1, 1);
    vecs[9]  = mk(0, 1, 1, 64'h200,  64'h8,   1, 64'hF0,   0, 0, 1);
    vecs[10] = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'hF0,   1, 0, 1);
    vecs[11] = mk(0, 1, 0, 64'h300,  64'h4,   1, 64'hF4,   1, 0, 1);
    vecs[12] = mk(0, 0, 1, 64'h300,  64'h4,   1, 64'hF8,   1, 0, 1);
    vecs[13] = mk(1, 0, 0, 64'h0,    64'h0,   1, 64'hF8,   0, 0, 1);
    vecs[14] = mk(1, 1, 1, 64'h40,   64'h1,   1, 64'h44,   0, 1, 2);
    vecs[15] = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'h44,   0, 0, 2);
    vecs[16] = mk(0, 0, 0, 64'h0,    64'h0,   1, 64'h44,   1, 0, 2);
    vecs[17] = mk(0, 1, 1, 64'h1003, 64'h2,   1, 64'h1008, 0, 1, 3);

    // Reset: outputs cleared, request held low even with stall low.
    rst = 1'b1;
    drive0(0, 0, 0, 0, 0, 1);
    drive1(0, 0, 0, 0, 0, 1);
    #12;
    check_out0("reset0", 64'h0, 0, 0, 0);
    check("reset1 addr", bus1.imem_addr, RPC1);
    check("reset1 req", 64'(bus1.imem_req), 64'd0);

    // Top-of-address-space wrap and stall+redirect on the second instance (3 bubbles).
    @(negedge clk);
    drive0(1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("wrap req", 64'(bus1.imem_req), 64'd1);
    check("wrap addr pre", bus1.imem_addr, RPC1);
    tick();
    check("wrap addr post", bus1.imem_addr, 64'h0);
    drive1(1, 1, 1, 64'h800, 64'h10, 1);
    tick();
    check("stallbr addr", bus1.imem_addr, 64'h840);
    check("stallbr flush", 64'(bus1.flush), 64'd1);
    check("stallbr cnt", 64'(bus1.taken_cnt), 64'd1);
    drive1(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stallbr bubble%0d req", i), 64'(bus1.imem_req), 64'd0);
      tick();
    end
    check("stallbr refetch req", 64'(bus1.imem_req), 64'd1);
    check("stallbr refetch addr", bus1.imem_addr, 64'h840);
    check("stallbr flush low", 64'(bus1.flush), 64'd0);
    drive1(1, 0, 0, 0, 0, 0);

    // Directed table on the default instance from a fresh reset.
    rst = 1'b1;
    drive0(0, 0, 0, 0, 0, 1);
    #3;
    rst = 1'b0;
    #1;
    check_out0("post-reset", 64'h0, 1, 0, 0);
    for (int i = 0; i < 18; i++) begin
      drive0(vecs[i].stall, vecs[i].bv, vecs[i].bt, vecs[i].bpc, vecs[i].boff, vecs[i].rdy);
      tick();
      check_out0($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_req, vecs[i].e_flush, vecs[i].e_cnt);
    end

    // Asynchronous reset while flush is high and the sequencer sits in FLUSH.
    drive0(0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    #1;
    check_out0("async reset", 64'h0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("after async reset req", 64'(bus0.imem_req), 64'd1);

    // Counter saturation from a preset near the top.
    tick();
    force dut0.taken_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut0.taken_cnt_q;
    for (int k = 0; k < 2; k++) begin
      drive0(0, 1, 1, 64'h2000, 64'h0, 1);
      tick();
      check($sformatf("sat%0d cnt", k), 64'(bus0.taken_cnt), 64'hFFFF_FFFF);
      check($sformatf("sat%0d flush", k), 64'(bus0.flush), 64'd1);
      drive0(0, 0, 0, 0, 0, 1);
      tick();
      tick();
    end

    // Randomized run against the behavioural model.
    rst = 1'b1;
    #3;
    rst = 1'b0;
    m_pc = 64'h0; m_bub = 0; m_flush = 1'b0; m_cnt = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic        s, v, t, r;
      logic [63:0] bpc, boff;
      s    = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 3) != 0);
      v    = ($urandom_range(0, 4) == 0);
      t    = 1'($urandom_range(0, 1));
      bpc  = {$urandom, $urandom};
      boff = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($signed(8'($urandom)));
      drive0(s, v, t, bpc, boff, r);
      #1;
      check($sformatf("rnd%0d req", n), 64'(bus0.imem_req), 64'((m_bub == 0) && !s));
      @(posedge clk);
      if (m_bub == 0 && v && t) begin
        m_pc    = (bpc + boff * 64'd4) & ~64'd3;
        m_flush = 1'b1;
        m_bub   = 2;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m_flush = 1'b0;
        if (m_bub > 0) m_bub = m_bub - 1;
        else if (!s && r) m_pc = m_pc + 64'd4;
      end
      #1;
      check($sformatf("rnd%0d addr", n), bus0.imem_addr, m_pc);
      check($sformatf("rnd%0d flush", n), 64'(bus0.flush), 64'(m_flush));
      check($sformatf("rnd%0d cnt", n), 64'(bus0.taken_cnt), 64'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer directly downstream of the branch decoder. Holds the 64-bit fetch PC, issues fetch requests to instruction memory over a req/ready handshake, advances PC by 4 on each accepted fetch, and redirects to the branch target when execute reports a resolved, taken branch. After a redirect it emits a one-cycle flush pulse and suppresses fetch for a fixed number of bubble cycles. It also keeps a saturating count of taken branches.

## Interface
- ADDR_W, 64, PC/address width.
- RESET_PC, 64'h0, PC value loaded on reset.
- FLUSH_CYCLES, 2, fetch-suppressed bubble cycles after a redirect (legal 1..15).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hazard hold; blocks new fetch requests.
- br_valid  in  1  branch resolved in execute this cycle.
- br_taken  in  1  branch-decoder taken result; qualified by br_valid.
- br_pc  in  ADDR_W  PC of the resolving branch.
- br_offset  in  ADDR_W  signed word offset, already sign-extended by decode.
- imem_ready  in  1  instruction memory accepts the request this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address (equals PC register).
- flush  out  1  one-cycle pulse: kill younger in-flight instructions.
- taken_cnt  out  32  taken-branch counter, saturates at 32'hFFFF_FFFF.

## Operation
- States: FETCH, FLUSH. Reset state: FETCH.
- imem_req = (state == FETCH) && !stall; combinational in stall. imem_addr = pc.
- Accept = imem_req && imem_ready. On accept: pc <= pc + 4, modulo 2^ADDR_W, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- While imem_req && !imem_ready: pc and imem_addr hold.
- Redirect = br_valid && br_taken && state == FETCH.
  - target = (br_pc + (br_offset << 2)) with bits [1:0] forced to 0. Arithmetic is ADDR_W wide and wraps.
  - pc <= target.
  - flush <= 1 for exactly one cycle.
  - Flush counter <= FLUSH_CYCLES; state <= FLUSH.
  - taken_cnt increments unless saturated.
- Priority: redirect > accept > hold. A simultaneous accept is discarded, so pc takes target, not pc+4. A redirect overrides stall.
- Redirect during an outstanding request abandons the request. imem_req may drop while imem_ready is low.
- FLUSH:
  - imem_req = 0.
  - Counter decrements each cycle. On the cycle it reaches 0, state <= FETCH.
  - br_valid and br_taken are ignored, because they come from wrong-path instructions. taken_cnt does not increment.
- Not-taken branch (br_valid && !br_taken): no effect.
- br_taken without br_valid: no effect.

## Timing
- Reset values (async, immediate on rst assertion):
  - pc = RESET_PC.
  - State = FETCH; flush counter = 0.
  - flush = 0; taken_cnt = 0.
  - imem_req = 0 while rst is high, then follows stall.
- Reset mid-FLUSH or mid-handshake returns to the reset state immediately. No pending redirect survives reset.
- Redirect latency:
  - Taken branch sampled at edge N.
  - Cycle N+1: flush = 1, imem_addr = target, imem_req = 0.
  - Cycles N+1 .. N+FLUSH_CYCLES: imem_req = 0.
  - Cycle N+FLUSH_CYCLES+1: imem_req reasserts at target (if !stall).
- Sequential fetch: one accepted fetch per cycle maximum, with zero bubbles when imem_ready is held high.

## Structure
- Shared package (pc_seq_pkg):
  - State enum {FETCH, FLUSH}.
  - PC_STEP = 4.
  - Default FLUSH_CYCLES.
  - Flush-counter width (4 bits).
- Sub-module pc_target_calc: combinational target adder (br_pc, br_offset -> aligned target), reusable by a future branch-target buffer.
- Sequential logic (PC register, FSM, counters) stays in pc_sequencer.

## Test plan
- Reset, then stall = 0 and imem_ready = 1 for 4 cycles -> imem_addr goes 0, 4, 8, 12; flush = 0; taken_cnt = 0.
- imem_ready low for 3 cycles at pc = 0x10 -> imem_addr holds 0x10 and imem_req stays 1; advances to 0x14 one cycle after ready rises.
- Taken branch with br_pc = 0x100 and br_offset = -4 (all ones pattern ...FFFC), while accept is also active -> next pc = 0xF0; flush is high for 1 cycle; imem_req is 0 for 2 cycles; then fetch at 0xF0; taken_cnt = 1.
- Taken branch during FLUSH, and a not-taken branch in FETCH -> both ignored; pc and taken_cnt unchanged.
- RESET_PC = 0xFFFF_FFFF_FFFF_FFFC, one accept -> pc = 0. Also stall = 1 combined with a taken branch -> redirect still occurs.
- rst asserted asynchronously mid-FLUSH, and taken_cnt preset near saturation (force to 0xFFFF_FFFE, then 2 taken branches) -> reset immediately clears all outputs; separately, taken_cnt saturates at 0xFFFF_FFFF.
